// File: rtl/pri_code_decoder_3_8.sv
// ============================================================================
// Module   : pri_code_decoder_3_8
// Purpose  : 3-to-8 one-hot decoder behind a 2-deep code FIFO; each code is
//            driven on y for HOLD cycles, back-to-back with no gap.
// Option   : PRI_DEC_STICKY_EN adds clr/acc (sticky OR of decoded words).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pri_code_decoder_3_8 #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] e,
  input  logic       v,
  output logic       rdy,
  output logic [7:0] y,
  output logic       yv
`ifdef PRI_DEC_STICKY_EN
  ,
  input  logic       clr,
  output logic [7:0] acc
`endif
);

  localparam logic [0:0] c_IDLE    = 1'b0;
  localparam logic [0:0] c_DRIVE   = 1'b1;
  localparam logic [3:0] c_HOLD_M1 = 4'(HOLD - 1);

  logic [2:0] r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;
  logic [0:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_y;

  logic       w_push;
  logic       w_pop;
  logic [7:0] w_dec;

  // rdy looks only at stored occupancy, so a pop at this edge never frees a slot early
  assign rdy    = ~rst & (r_occ < 2'd2);
  assign w_push = v & rdy;
  assign w_pop  = (r_occ != 2'd0) & ((r_state == c_IDLE) | (r_cnt == 4'd0));
  assign w_dec  = 8'b1 << r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
      r_y     <= 8'h00;
    end else if (w_pop) begin
      r_state <= c_DRIVE;
      r_cnt   <= c_HOLD_M1;
      r_y     <= w_dec;
    end else if (r_state == c_DRIVE) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_state <= c_IDLE;
        r_y     <= 8'h00;
      end
    end
  end

  assign y  = r_y;
  assign yv = (r_state == c_DRIVE);

`ifdef PRI_DEC_STICKY_EN
  logic [7:0] r_acc;

  // a clear coinciding with a load keeps only the newly loaded bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 8'h00;
    end else if (w_pop) begin
      r_acc <= (clr ? 8'h00 : r_acc) | w_dec;
    end else if (clr) begin
      r_acc <= 8'h00;
    end
  end

  assign acc = r_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pri_code_decoder_3_8.sv
// ============================================================================
// Module   : tb_pri_code_decoder_3_8
// Purpose  : Directed vector table, sticky-accumulator sequences and random
//            traffic against a queue-based reference of pri_code_decoder_3_8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pri_code_decoder_3_8;

  localparam int HOLD = 2;

  logic       clk;
  logic       rst;
  logic [2:0] e;
  logic       v;
  logic       rdy;
  logic [7:0] y;
  logic       yv;
  logic       clr;
`ifdef PRI_DEC_STICKY_EN
  logic [7:0] acc;
`endif

  pri_code_decoder_3_8 #(.HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .e   (e),
    .v   (v),
    .rdy (rdy),
    .y   (y),
    .yv  (yv)
`ifdef PRI_DEC_STICKY_EN
    ,
    .clr (clr),
    .acc (acc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference: queue of waiting codes, the code on display and how many
  // more cycles it remains visible (0 = nothing shown).
  int         mq[$];
  int         m_act = 0;
  int         m_rem = 0;
  logic [7:0] m_acc = 8'h00;
  logic       s_rdy;

  function automatic logic [7:0] m_y();
    return (m_rem > 0) ? 8'(1 << m_act) : 8'h00;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_asrt++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic model_step(input logic r_i, input logic v_i, input logic [2:0] e_i, input logic c_i);
    logic accept;
    logic loaded;
    if (r_i) begin
      mq.delete();
      m_rem = 0;
      m_acc = 8'h00;
    end else begin
      accept = v_i && (mq.size() < 2);
      loaded = 1'b0;
      if (m_rem > 1) begin
        m_rem--;
      end else if (mq.size() > 0) begin
        m_act  = mq.pop_front();
        m_rem  = HOLD;
        loaded = 1'b1;
      end else begin
        m_rem = 0;
      end
      if (accept) mq.push_back(int'(e_i));
      if (loaded) m_acc = (c_i ? 8'h00 : m_acc) | 8'(1 << m_act);
      else if (c_i) m_acc = 8'h00;
    end
  endtask

  // One clock: drive, sample rdy before the edge, step the model, sample after.
  task automatic run_cycle(input logic r_i, input logic v_i, input logic [2:0] e_i, input logic c_i);
    rst = r_i; v = v_i; e = e_i; clr = c_i;
    #1;
    s_rdy = rdy;
    check("rdy_model", {7'd0, rdy}, {7'd0, (!r_i && (mq.size() < 2))});
    @(posedge clk);
    model_step(r_i, v_i, e_i, c_i);
    cyc++;
    #1;
    check("y_model", y, m_y());
    check("yv_model", {7'd0, yv}, {7'd0, (m_rem > 0)});
`ifdef PRI_DEC_STICKY_EN
    check("acc_model", acc, m_acc);
`endif
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [2:0] e;
    logic       chk_rdy;
    logic       rdy;
    logic [7:0] y;
    logic       yv;
  } vec_t;

  vec_t tbl[29];

  initial begin
    rst = 1'b1; v = 1'b0; e = 3'd0; clr = 1'b0;

    // Reset with a simultaneous push, then e=5 for one cycle.
    tbl[0]  = '{1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h20, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h20, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    // Codes 0,7,3 back to back; rdy constrained only while pushing.
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h80, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h80, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h08, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h08, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    // Four pushes; the fourth (e=6) arrives with rdy=0 and is dropped.
    tbl[14] = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 8'h02, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h02, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'h04, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h04, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h08, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h08, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    // Reset while driving code 4 with 5 and 6 queued.
    tbl[22] = '{1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'h10, 1'b1};
    tbl[24] = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 8'h10, 1'b1};
    tbl[25] = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[28] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 29; i++) begin
      run_cycle(tbl[i].r, tbl[i].v, tbl[i].e, 1'b0);
      if (tbl[i].chk_rdy) check($sformatf("tbl%0d_rdy", i), {7'd0, s_rdy}, {7'd0, tbl[i].rdy});
      check($sformatf("tbl%0d_y", i), y, tbl[i].y);
      check($sformatf("tbl%0d_yv", i), {7'd0, yv}, {7'd0, tbl[i].yv});
    end

`ifdef PRI_DEC_STICKY_EN
    run_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    check("acc_reset", acc, 8'h00);
    run_cycle(1'b0, 1'b1, 3'd1, 1'b0);
    run_cycle(1'b0, 1'b1, 3'd4, 1'b0);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 3'd0, 1'b0);
    check("acc_1_4", acc, 8'h12);
    run_cycle(1'b0, 1'b0, 3'd0, 1'b1);
    check("acc_clr", acc, 8'h00);
    run_cycle(1'b0, 1'b1, 3'd1, 1'b0);
    run_cycle(1'b0, 1'b1, 3'd2, 1'b0);
    run_cycle(1'b0, 1'b0, 3'd0, 1'b0);
    check("acc_pre_load", acc, 8'h02);
    run_cycle(1'b0, 1'b0, 3'd0, 1'b1);
    check("acc_clr_load", acc, 8'h04);
    check("y_clr_load", y, 8'h04);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 3'd0, 1'b0);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
